// File: rtl/vaddubm_seq.sv
// Four-lane unsigned byte vector add (modulo or saturating), one lane per clock.
// Latency 4 edges from accept to out_valid; result holds in DONE until out_ready.
module vaddubm_seq #(
  parameter int SAT_EN = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] vra,
  input  logic [31:0] vrb,
  input  logic        sat_mode,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] vrt,
  output logic        sat,
  output logic        sat_sticky,
  input  logic        sat_clr
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [1:0]  lane_q, lane_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic        mode_q, mode_d;
  logic [31:0] acc_q, acc_d;
  logic        opsat_q, opsat_d;
  logic [31:0] vrt_q, vrt_d;
  logic        sat_q, sat_d;
  logic        sticky_q, sticky_d;

  logic [4:0]  lsb;
  logic [7:0]  lane_a, lane_b, lane_res;
  logic [8:0]  lane_sum;
  logic        lane_sat;
  logic        done_set;

  always_comb begin
    lsb      = {lane_q, 3'b000};
    lane_a   = a_q[lsb +: 8];
    lane_b   = b_q[lsb +: 8];
    lane_sum = {1'b0, lane_a} + {1'b0, lane_b};
    lane_sat = mode_q & lane_sum[8];
    lane_res = lane_sat ? 8'hFF : lane_sum[7:0];

    state_d  = state_q;
    lane_d   = lane_q;
    a_d      = a_q;
    b_d      = b_q;
    mode_d   = mode_q;
    acc_d    = acc_q;
    opsat_d  = opsat_q;
    vrt_d    = vrt_q;
    sat_d    = sat_q;
    done_set = 1'b0;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = vra;
          b_d     = vrb;
          mode_d  = sat_mode & (SAT_EN != 0);
          lane_d  = 2'd0;
          opsat_d = 1'b0;
          state_d = CALC;
        end
      end
      CALC: begin
        acc_d[lsb +: 8] = lane_res;
        opsat_d         = opsat_q | lane_sat;
        lane_d          = lane_q + 2'd1;
        if (lane_q == 2'd3) begin
          // Lane3 result is not yet in acc_q, so splice it in directly.
          vrt_d    = {lane_res, acc_q[23:0]};
          sat_d    = opsat_q | lane_sat;
          done_set = opsat_q | lane_sat;
          state_d  = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A saturation landing on the same edge as a clear must survive.
    if (done_set)     sticky_d = 1'b1;
    else if (sat_clr) sticky_d = 1'b0;
    else              sticky_d = sticky_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      lane_q   <= 2'd0;
      a_q      <= '0;
      b_q      <= '0;
      mode_q   <= 1'b0;
      acc_q    <= '0;
      opsat_q  <= 1'b0;
      vrt_q    <= '0;
      sat_q    <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      lane_q   <= lane_d;
      a_q      <= a_d;
      b_q      <= b_d;
      mode_q   <= mode_d;
      acc_q    <= acc_d;
      opsat_q  <= opsat_d;
      vrt_q    <= vrt_d;
      sat_q    <= sat_d;
      sticky_q <= sticky_d;
    end
  end

  assign in_ready   = (state_q == IDLE) && !rst;
  assign out_valid  = (state_q == DONE);
  assign vrt        = vrt_q;
  assign sat        = sat_q;
  assign sat_sticky = sticky_q;

endmodule

// File: tb/tb_vaddubm_seq.sv
// Directed bench for vaddubm_seq: two instances (SAT_EN=1 and SAT_EN=0) share stimulus,
// expected results come from a per-lane reference model through scoreboard queues.
module tb_vaddubm_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] vra = '0;
  logic [31:0] vrb = '0;
  logic        sat_mode = 1'b0;
  logic        out_ready = 1'b0;
  logic        sat_clr = 1'b0;

  logic        in_ready0, out_valid0, sat0, sticky0;
  logic        in_ready1, out_valid1, sat1, sticky1;
  logic [31:0] vrt0, vrt1;

  int errors = 0;
  int checks = 0;

  logic [32:0] q0[$];
  logic [32:0] q1[$];

  always #5 clk = ~clk;

  vaddubm_seq #(.SAT_EN(1)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
    .vra(vra), .vrb(vrb), .sat_mode(sat_mode), .out_valid(out_valid0),
    .out_ready(out_ready), .vrt(vrt0), .sat(sat0), .sat_sticky(sticky0),
    .sat_clr(sat_clr)
  );

  vaddubm_seq #(.SAT_EN(0)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
    .vra(vra), .vrb(vrb), .sat_mode(sat_mode), .out_valid(out_valid1),
    .out_ready(out_ready), .vrt(vrt1), .sat(sat1), .sat_sticky(sticky1),
    .sat_clr(sat_clr)
  );

  // Returns {sat, vrt}
  function automatic logic [32:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic m);
    logic [31:0] r;
    logic        s;
    logic [8:0]  sum;
    r = '0;
    s = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sum = {1'b0, a[i*8 +: 8]} + {1'b0, b[i*8 +: 8]};
      if (m && sum[8]) begin
        r[i*8 +: 8] = 8'hFF;
        s = 1'b1;
      end else begin
        r[i*8 +: 8] = sum[7:0];
      end
    end
    return {s, r};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one op and wait for DONE; optionally pulse sat_clr on the DONE-entry edge.
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic m,
                      input logic clr_on_done);
    logic [31:0] held0;
    logic [32:0] e0, e1;
    int lat;
    chk("in_ready_before_accept", {31'd0, in_ready0}, 32'd1);
    vra = a; vrb = b; sat_mode = m; in_valid = 1'b1;
    q0.push_back(model(a, b, m));
    q1.push_back(model(a, b, 1'b0));
    held0 = vrt0;
    step();
    in_valid = 1'b0;
    lat = 0;
    for (int i = 1; i <= 8; i++) begin
      if (clr_on_done && i == 4) sat_clr = 1'b1;
      step();
      sat_clr = 1'b0;
      if (out_valid0) begin
        lat = i;
        break;
      end
      chk("vrt_stable_in_calc", vrt0, held0);
    end
    chk("latency", lat, 4);
    chk("valid_pair", {31'd0, out_valid1}, 32'd1);
    e0 = q0.pop_front();
    e1 = q1.pop_front();
    chk("vrt_sat_en1", vrt0, e0[31:0]);
    chk("sat_sat_en1", {31'd0, sat0}, {31'd0, e0[32]});
    chk("vrt_sat_en0", vrt1, e1[31:0]);
    chk("sat_sat_en0", {31'd0, sat1}, {31'd0, e1[32]});
  endtask

  task automatic handshake();
    logic [31:0] r0;
    logic        s0;
    r0 = vrt0;
    s0 = sat0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("out_valid_after_hs", {31'd0, out_valid0}, 32'd0);
    chk("in_ready_after_hs", {31'd0, in_ready0}, 32'd1);
    chk("vrt_held_after_hs", vrt0, r0);
    chk("sat_held_after_hs", {31'd0, sat0}, {31'd0, s0});
  endtask

  initial begin
    logic [31:0] held;
    logic [31:0] ra, rb;

    // Reset values
    #2;
    chk("rst_vrt", vrt0, 32'd0);
    chk("rst_sat", {31'd0, sat0}, 32'd0);
    chk("rst_sticky", {31'd0, sticky0}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid0}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready0}, 32'd0);
    step();
    step();
    rst = 1'b0;
    #1;
    chk("in_ready_after_rst", {31'd0, in_ready0}, 32'd1);
    step();

    // Modulo
    send(32'h01FF7F80, 32'h01010181, 1'b0, 1'b0);
    chk("mod_vrt_const", vrt0, 32'h02008001);
    chk("mod_sticky", {31'd0, sticky0}, 32'd0);
    handshake();

    // Saturating, plus SAT_EN=0 instance must stay modulo
    send(32'h01FF7F80, 32'h01010181, 1'b1, 1'b0);
    chk("sat_vrt_const", vrt0, 32'h02FF80FF);
    chk("sat_flag_const", {31'd0, sat0}, 32'd1);
    chk("sat_sticky_set", {31'd0, sticky0}, 32'd1);
    chk("sat_en0_vrt_const", vrt1, 32'h02008001);
    chk("sat_en0_sticky", {31'd0, sticky1}, 32'd0);
    handshake();
    sat_clr = 1'b1;
    step();
    sat_clr = 1'b0;
    chk("sticky_cleared", {31'd0, sticky0}, 32'd0);

    // Set wins over a simultaneous clear; backpressure with ignored in_valid
    send(32'h80808080, 32'h80808080, 1'b1, 1'b1);
    chk("sticky_set_wins", {31'd0, sticky0}, 32'd1);
    held = vrt0;
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      vra = 32'h12345678;
      step();
      chk("bp_out_valid", {31'd0, out_valid0}, 32'd1);
      chk("bp_vrt", vrt0, held);
      chk("bp_in_ready", {31'd0, in_ready0}, 32'd0);
    end
    in_valid = 1'b0;
    handshake();
    sat_clr = 1'b1;
    step();
    sat_clr = 1'b0;
    chk("sticky_clr_alone", {31'd0, sticky0}, 32'd0);
    send(32'h10203040, 32'h01020304, 1'b1, 1'b0);
    chk("sticky_stays_0", {31'd0, sticky0}, 32'd0);
    handshake();

    // Reset during CALC after lane1
    vra = 32'h0F0F0F0F; vrb = 32'hF1F1F1F1; sat_mode = 1'b1; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    rst = 1'b1;
    #1;
    chk("abort_vrt", vrt0, 32'd0);
    chk("abort_sat", {31'd0, sat0}, 32'd0);
    chk("abort_sticky", {31'd0, sticky0}, 32'd0);
    chk("abort_out_valid", {31'd0, out_valid0}, 32'd0);
    chk("abort_in_ready", {31'd0, in_ready0}, 32'd0);
    step();
    rst = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("abort_no_output", {31'd0, out_valid0}, 32'd0);
    end
    send(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0);
    chk("post_abort_vrt", vrt0, 32'hFFFFFF00);
    handshake();

    // A few random ops through the model
    for (int n = 0; n < 6; n++) begin
      ra = $urandom;
      rb = $urandom;
      send(ra, rb, n[0], 1'b0);
      handshake();
    end

    chk("scoreboard_empty", q0.size() + q1.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
